fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
- Read-side consumer for the team's synchronous FIFO (FIFO_WIDTH=16, FIFO_DEPTH=8).
- Drives the FIFO's rd_en, captures its registered data_out, and presents the words downstream on a valid/ready stream.
- A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency, so full throughput is kept under backpressure.
- Also counts delivered words and flags underflow as a sticky error.

Parameters:
- FIFO_WIDTH, 16, data word width; must match the FIFO.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  in  1  single clock; all flops rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  high = reads may be issued; low = no new reads, but in-flight and buffered words still drain.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data_out  in  FIFO_WIDTH  FIFO read data; valid the cycle after rd_en is sampled.
- fifo_underflow  in  1  FIFO underflow flag; qualifies the same data cycle.
- fifo_rd_en  out  1  read request to the FIFO.
- m_data  out  FIFO_WIDTH  downstream data (head of skid buffer).
- m_valid  out  1  downstream valid.
- m_ready  in  1  downstream ready.
- err_clr  in  1  clears underflow_err.
- underflow_err  out  1  sticky: a read returned underflow.
- rd_count  out  CNT_WIDTH  downstream handshakes completed, modulo 2^CNT_WIDTH.
- busy  out  1  in-flight read or buffered data present.

Behaviour:
- Reset (async on rst_n low): occ=0, inflight=0, underflow_err=0, rd_count=0, buffer contents=0.
  - Outputs during reset: m_valid=0, m_data=0, fifo_rd_en=0, busy=0.
  - Release is synchronous to the next clk edge.
- State is occupancy occ in {EMPTY=0, ONE=1, TWO=2} plus the inflight bit.
  - inflight <= fifo_rd_en every cycle.
- Outputs:
  - pop = m_valid & m_ready.
  - m_valid = (occ != 0); m_data = entry[head].
  - busy = inflight | (occ != 0).
- Read issue (combinational): fifo_rd_en = enable & ~fifo_empty & ((occ + inflight - pop) < 2).
  - Guarantees the buffer never overflows.
  - Steady streaming with m_ready=1 gives one word per cycle after 2 cycles of startup latency (rd_en at cycle 0, data captured at edge ending cycle 1, m_valid in cycle 2).
- Capture: in a cycle with inflight=1 and fifo_underflow=0, push fifo_data_out at the clock edge.
  - With inflight=1 and fifo_underflow=1: discard the word, set underflow_err, occ unchanged.
- Occupancy update:
  - Push and pop in the same cycle: occ unchanged; head advances; new word goes to tail.
  - Push only: occ+1. Pop only: occ-1.
  - Push into TWO cannot occur; the issue rule prevents it. Bench asserts this.
- Ordering: strict FIFO order, head entry first. Ring pointer, 1-bit head, wraps 1 -> 0.
- m_data is held stable while m_valid=1 and m_ready=0; the valid/ready rule holds.
- enable falling: fifo_rd_en drops the same cycle. The pending inflight word is still captured; buffered words still drain.
- fifo_empty high: no rd_en. An inflight word issued before empty asserted is still captured.
- rd_count increments by 1 on each pop and wraps from 2^CNT_WIDTH-1 to 0.
- underflow_err: set has priority over err_clr in the same cycle; otherwise err_clr clears it the next edge.
- Reset mid-operation: buffered and in-flight words are lost; no output glitch beyond going to reset values.

Test Plan:
- FIFO preloaded with 0x0001..0x0008, enable=1, m_ready=1 -> rd_en cycles 0-7; m_valid cycles 2-9 with m_data 0x0001..0x0008 in order; rd_count=8; busy=0 from cycle 10.
- Same preload, m_ready=0 for cycles 0-9 then 1 -> rd_en only in cycles 0-1; occ=2 holding 0x0001/0x0002 stable; after release all 8 words delivered in order, no loss or duplication.
- m_ready toggling 1,0,1,0 with 8 words -> 8 handshakes, order preserved, occ never exceeds 2 (assertion).
- enable dropped in the cycle after the 3rd rd_en -> exactly 3 words delivered (0x0001..0x0003); fifo_rd_en=0 thereafter; busy falls after last pop.
- Force fifo_underflow=1 on an inflight cycle -> no push, underflow_err=1 next edge, held; err_clr pulse clears it; err_clr coinciding with a new underflow leaves it set.
- CNT_WIDTH=4, 17 words delivered -> rd_count=1. Assert rst_n low with occ=2 -> m_valid, fifo_rd_en, busy = 0 immediately (async), rd_count=0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the synchronous FIFO: issues rd_en, captures the registered
// read data into a 2-entry skid buffer and streams it out on a valid/ready interface.
module fifo_stream_reader #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  err_clr,
  output logic                  underflow_err,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                  occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  head_q, head_d;
  logic [FIFO_WIDTH-1:0] entry0_q, entry0_d;
  logic [FIFO_WIDTH-1:0] entry1_q, entry1_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic       pop;
  logic       push;
  logic       tail;
  logic [2:0] pending;

  always_comb begin
    occ_d      = occ_q;
    head_d     = head_q;
    entry0_d   = entry0_q;
    entry1_d   = entry1_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    m_valid    = (occ_q != OCC_EMPTY);
    pop        = m_valid & m_ready;
    // Words already owned (buffered + in flight) minus the one leaving this cycle.
    pending    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = rst_n & enable & ~fifo_empty & (pending < 3'd2);
    inflight_d = fifo_rd_en;

    push       = inflight_q & ~fifo_underflow;
    tail       = head_q ^ (occ_q == OCC_ONE);

    if (push) begin
      if (tail) entry1_d = fifo_data_out;
      else      entry0_d = fifo_data_out;
    end

    if (pop) begin
      head_d = ~head_q;
      cnt_d  = cnt_q + CNT_WIDTH'(1);
    end

    case ({push, pop})
      2'b10:   occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_TWO;
      2'b01:   occ_d = (occ_q == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
      default: occ_d = occ_q;
    endcase

    if (inflight_q & fifo_underflow) err_d = 1'b1;
    else if (err_clr)                err_d = 1'b0;

    m_data        = head_q ? entry1_q : entry0_q;
    busy          = inflight_q | m_valid;
    underflow_err = err_q;
    rd_count      = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= OCC_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      entry0_q   <= '0;
      entry1_q   <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      entry0_q   <= entry0_d;
      entry1_q   <= entry1_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
